reg_bus_arbiter: RTL and testbench

REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

---
 rtl/ctrl_pkg.sv | 7 +
 rtl/rr_pick2.sv | 10 +
 rtl/reg_bus_arbiter.sv | 116 +++++++++++
 tb/tb_reg_bus_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared FSM state encoding and parameter defaults for the register bus arbiter
package ctrl_pkg;
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;
   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;
   localparam int RD_LAT_DEF = 1;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin picker favouring the requester not served last
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant,
   output logic       valid
);
   assign valid = |req;
   assign grant = &req ? ~last : req[1];
endmodule

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: arbitrates two register-bus requesters onto one register file port
module reg_bus_arbiter
   import ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int RD_LAT = RD_LAT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req,
   input  logic              m0_wr,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_wr,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   output logic              reg_wr,
   output logic              reg_rd,
   input  logic [DATA_W-1:0] reg_rdata,
   output logic              busy,
   output logic              owner
);
   state_t            state, nxt;
   logic [1:0]        pend, eff, own_mask, gnt_mask;
   logic [1:0]        cnt;
   logic              last, win, any, start, lat_wr, win_wr, rd_done;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;

   assign eff       = {m1_req | pend[1], m0_req | pend[0]};
   assign win_wr    = win ? m1_wr : m0_wr;
   assign win_addr  = win ? m1_addr : m0_addr;
   assign win_wdata = win ? m1_wdata : m0_wdata;
   assign start     = state == S_IDLE && any;
   assign rd_done   = state == S_WAIT && cnt == 2'd0;
   assign own_mask  = state != S_IDLE ? {owner, ~owner} : 2'b00;
   assign gnt_mask  = start ? {win, ~win} : 2'b00;

   rr_pick2 u_pick (.req(eff), .last(last), .grant(win), .valid(any));

   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_IDLE;
      else state <= nxt;

   // next-state: issue one cycle, then ack directly for writes or after the read wait
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:  nxt = any ? S_ISSUE : S_IDLE;
         S_ISSUE: nxt = lat_wr ? S_ACK : S_WAIT;
         S_WAIT:  nxt = cnt == 2'd0 ? S_ACK : S_WAIT;
         default: nxt = S_IDLE;
      endcase
   end

   // latch the winning request and drive the one-cycle register strobes
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         owner     <= 1'b0;
         lat_wr    <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_wr    <= 1'b0;
         reg_rd    <= 1'b0;
      end else begin
         reg_wr <= start & win_wr;
         reg_rd <= start & ~win_wr;
         if (start) begin
            owner     <= win;
            lat_wr    <= win_wr;
            reg_addr  <= win_addr;
            reg_wdata <= win_wdata;
         end
      end

   // read latency countdown, loaded while the read strobe is out
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= 2'd0;
      else if (state == S_ISSUE) cnt <= 2'(RD_LAT - 1);
      else if (state == S_WAIT) cnt <= cnt - 2'd1;

   // capture read data on the last wait cycle and pulse the owner's ack
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m0_ack   <= 1'b0;
         m1_ack   <= 1'b0;
         m0_rdata <= '0;
         m1_rdata <= '0;
      end else begin
         m0_ack <= nxt == S_ACK && !owner;
         m1_ack <= nxt == S_ACK && owner;
         if (rd_done && !owner) m0_rdata <= reg_rdata;
         if (rd_done && owner) m1_rdata <= reg_rdata;
      end

   // busy flag, last-served pointer and requests remembered while the bus is taken
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         busy <= 1'b0;
         last <= 1'b1;
         pend <= 2'b00;
      end else begin
         busy <= nxt != S_IDLE;
         if (state == S_ACK) last <= owner;
         pend <= (pend | ({m1_req, m0_req} & ~own_mask)) & ~gnt_mask;
      end
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: directed vectors, corner sequences and randomized model checks
module tb_reg_bus_arbiter;
   localparam int RDLAT = 1;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic       m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
   logic [7:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0, reg_rdata = '0;
   logic       m0_ack, m1_ack, reg_wr, reg_rd, busy, owner;
   logic [7:0] m0_rdata, m1_rdata, reg_addr, reg_wdata;
   logic       d3_m0_ack, d3_m1_ack, d3_reg_wr, d3_reg_rd, d3_busy, d3_owner;
   logic [7:0] d3_m0_rdata, d3_m1_rdata, d3_reg_addr, d3_reg_wdata;
   int         n_chk = 0, n_fail = 0;

   typedef struct {
      int         m;
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] rdata;
      int         exp_k;
   } vec_t;
   vec_t tbl[5];

   logic       rq[2], rwr[2];
   logic [7:0] raddr[2], rwd[2];
   int         issue_c, ack_c, mown, w;
   logic       cur_wr, last_m;
   logic [1:0] pend_m, eff;
   logic [7:0] e_addr, e_wdata, e_rd[2];

   always #5 clk = ~clk;

   reg_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
      .reg_rdata(reg_rdata), .busy(busy), .owner(owner)
   );

   reg_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(d3_m0_ack), .m0_rdata(d3_m0_rdata),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(d3_m1_ack), .m1_rdata(d3_m1_rdata),
      .reg_addr(d3_reg_addr), .reg_wdata(d3_reg_wdata), .reg_wr(d3_reg_wr), .reg_rd(d3_reg_rd),
      .reg_rdata(reg_rdata), .busy(d3_busy), .owner(d3_owner)
   );

   task automatic chk1(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input int m, input logic req, input logic wr, input logic [7:0] a, input logic [7:0] d);
      if (m == 0) begin
         m0_req = req; m0_wr = wr; m0_addr = a; m0_wdata = d;
      end else begin
         m1_req = req; m1_wr = wr; m1_addr = a; m1_wdata = d;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
      drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // single transaction from idle: request seen in cycle T, checks cycles T+1 .. T+exp_k+2
   task automatic do_txn(input int m, input logic wr, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] rd, input int exp_k, input string tag);
      @(negedge clk);
      drive(m, 1'b1, wr, a, d);
      reg_rdata = rd;
      for (int k = 1; k <= exp_k + 2; k++) begin
         @(negedge clk);
         chk1({tag, " reg_wr"}, reg_wr, k == 1 && wr);
         chk1({tag, " reg_rd"}, reg_rd, k == 1 && !wr);
         chk1({tag, " busy"}, busy, k <= exp_k);
         chk1({tag, " m0_ack"}, m0_ack, k == exp_k && m == 0);
         chk1({tag, " m1_ack"}, m1_ack, k == exp_k && m == 1);
         if (k == 1) begin
            chk8({tag, " reg_addr"}, reg_addr, a);
            chk1({tag, " owner"}, owner, m == 1);
            if (wr) chk8({tag, " reg_wdata"}, reg_wdata, d);
         end
         if (k == exp_k) begin
            if (!wr) chk8({tag, " rdata"}, m == 0 ? m0_rdata : m1_rdata, rd);
            drive(m, 1'b0, wr, a, d);
         end
      end
   endtask

   initial begin
      tbl[0] = '{m: 0, wr: 1'b1, addr: 8'h01, wdata: 8'hA5, rdata: 8'h00, exp_k: 2};
      tbl[1] = '{m: 1, wr: 1'b0, addr: 8'h02, wdata: 8'h00, rdata: 8'h3C, exp_k: 2 + RDLAT};
      tbl[2] = '{m: 0, wr: 1'b0, addr: 8'hFF, wdata: 8'h12, rdata: 8'hC3, exp_k: 2 + RDLAT};
      tbl[3] = '{m: 1, wr: 1'b1, addr: 8'h80, wdata: 8'h7E, rdata: 8'h00, exp_k: 2};
      tbl[4] = '{m: 0, wr: 1'b1, addr: 8'h00, wdata: 8'hFF, rdata: 8'h00, exp_k: 2};

      // reset state
      @(negedge clk);
      chk1("rst busy", busy, 1'b0);
      chk1("rst owner", owner, 1'b0);
      chk1("rst m0_ack", m0_ack, 1'b0);
      chk1("rst m1_ack", m1_ack, 1'b0);
      chk1("rst reg_wr", reg_wr, 1'b0);
      chk1("rst reg_rd", reg_rd, 1'b0);
      chk8("rst reg_addr", reg_addr, 8'h00);
      chk8("rst reg_wdata", reg_wdata, 8'h00);
      chk8("rst m0_rdata", m0_rdata, 8'h00);
      chk8("rst m1_rdata", m1_rdata, 8'h00);
      chk1("rst d3 busy", d3_busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // directed single transactions
      for (int i = 0; i < 5; i++)
         do_txn(tbl[i].m, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].exp_k, $sformatf("vec%0d", i));

      // both requesting from reset and held: m0, m1, m0, m1, then m0's pending request
      do_reset();
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 8'h10, 8'h11);
      drive(1, 1'b1, 1'b1, 8'h20, 8'h22);
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         chk1("rr m0_ack", m0_ack, k == 2 || k == 8 || k == 14);
         chk1("rr m1_ack", m1_ack, k == 5 || k == 11);
         chk1("rr busy", busy, k % 3 != 0 && k < 15);
         if (k % 3 == 1 && k < 15) chk1("rr owner", owner, (k / 3) % 2 == 1);
         if (k >= 11 && m1_ack) m1_req = 1'b0;
         if (k >= 11 && m0_ack) m0_req = 1'b0;
      end

      // m1 arrives while an m0 read waits: served right after, exactly once
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 8'h33, 8'h00);
      reg_rdata = 8'h5A;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         chk1("late m0_ack", m0_ack, k == 3);
         chk1("late m1_ack", m1_ack, k == 6);
         if (k == 2) drive(1, 1'b1, 1'b1, 8'h44, 8'h77);
         if (k == 3) begin
            chk8("late m0_rdata", m0_rdata, 8'h5A);
            m0_req = 1'b0;
         end
         if (k == 5) begin
            chk1("late owner", owner, 1'b1);
            chk1("late reg_wr", reg_wr, 1'b1);
            chk8("late reg_addr", reg_addr, 8'h44);
         end
         if (k == 6) m1_req = 1'b0;
      end

      // reset during the read wait discards the transaction
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 8'h55, 8'h00);
      reg_rdata = 8'h96;
      @(negedge clk);
      chk1("rstw reg_rd", reg_rd, 1'b1);
      @(negedge clk);
      chk1("rstw busy wait", busy, 1'b1);
      rst_n = 1'b0;
      m0_req = 1'b0;
      #1;
      chk1("rstw busy", busy, 1'b0);
      chk1("rstw reg_rd", reg_rd, 1'b0);
      chk1("rstw m0_ack", m0_ack, 1'b0);
      chk8("rstw reg_addr", reg_addr, 8'h00);
      chk8("rstw reg_wdata", reg_wdata, 8'h00);
      chk8("rstw m0_rdata", m0_rdata, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk1("rstw late ack", m0_ack | m1_ack, 1'b0);
         chk1("rstw idle", busy | reg_rd | reg_wr, 1'b0);
      end
      do_txn(0, 1'b1, 8'h66, 8'h99, 8'h00, 2, "postrst");

      // three-cycle read latency: ack at T+5 with data from cycle T+4
      do_reset();
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
      reg_rdata = 8'h40;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         chk1("lat3 m0_ack", d3_m0_ack, k == 5);
         chk1("lat3 busy", d3_busy, k <= 5);
         chk1("lat3 reg_rd", d3_reg_rd, k == 1);
         if (k == 5) begin
            chk8("lat3 m0_rdata", d3_m0_rdata, 8'h44);
            m0_req = 1'b0;
         end
         reg_rdata = 8'(8'h40 + k);
      end

      // randomized traffic against a timestamp model
      do_reset();
      issue_c = -10; ack_c = -10; mown = 0; cur_wr = 1'b0; last_m = 1'b1; pend_m = 2'b00;
      e_addr = '0; e_wdata = '0; e_rd[0] = '0; e_rd[1] = '0;
      rq[0] = 1'b0; rq[1] = 1'b0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         chk1("rnd reg_wr", reg_wr, c == issue_c && cur_wr);
         chk1("rnd reg_rd", reg_rd, c == issue_c && !cur_wr);
         chk1("rnd busy", busy, c >= issue_c && c <= ack_c);
         chk1("rnd m0_ack", m0_ack, c == ack_c && mown == 0);
         chk1("rnd m1_ack", m1_ack, c == ack_c && mown == 1);
         chk1("rnd owner", owner, mown == 1);
         chk8("rnd reg_addr", reg_addr, e_addr);
         chk8("rnd reg_wdata", reg_wdata, e_wdata);
         chk8("rnd m0_rdata", m0_rdata, e_rd[0]);
         chk8("rnd m1_rdata", m1_rdata, e_rd[1]);
         for (int i = 0; i < 2; i++) begin
            if (rq[i] && c == ack_c && mown == i) rq[i] = $urandom_range(0, 3) == 0;
            else if (!rq[i]) rq[i] = $urandom_range(0, 2) == 0;
            else continue;
            rwr[i] = 1'($urandom_range(0, 1));
            raddr[i] = 8'($urandom);
            rwd[i] = 8'($urandom);
            drive(i, rq[i], rwr[i], raddr[i], rwd[i]);
         end
         reg_rdata = 8'($urandom);
         if (c > ack_c) begin
            eff = {rq[1] | pend_m[1], rq[0] | pend_m[0]};
            if (eff != 2'b00) begin
               w = eff == 2'b11 ? int'(!last_m) : int'(eff[1]);
               pend_m[w] = 1'b0;
               pend_m[1 - w] = pend_m[1 - w] | rq[1 - w];
               mown = w;
               cur_wr = rwr[w];
               e_addr = raddr[w];
               e_wdata = rwd[w];
               issue_c = c + 1;
               ack_c = c + 2 + (cur_wr ? 0 : RDLAT);
            end
         end else begin
            for (int i = 0; i < 2; i++) if (rq[i] && mown != i) pend_m[i] = 1'b1;
            if (!cur_wr && c == ack_c - 1) e_rd[mown] = reg_rdata;
            if (c == ack_c) last_m = mown == 1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
